// File: rtl/risc_eunit_p.sv
// risc_eunit_p -- parametrised execution unit for the RISC core.
//
// Takes one decoded instruction per valid/ready handshake and produces a
// registered result, destination, memory address and qualified enables for
// data memory and register-file writeback. ALU, shift and rotate ops finish
// one cycle after acceptance. MUL runs an iterative shift-add loop and holds
// off decode (in_rdy=0) until it completes. A registered {Z,N,C,V} flag
// register is updated by every computing op.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous abort of the in-flight / issuing op
//   in_vld, in_rdy  decode handshake (transfer on in_vld & in_rdy at posedge)
//   opcode          5-bit operation code
//   oprnd_a/b       operands (oprnd_b is also the shift/rotate amount)
//   dstin, dmaddrin destination register / data-memory address
//   out_vld         one-cycle pulse marking a completed op
//   rslt, dst, dmaddr  registered result / destination / address
//   dmenbl, rdwr    memory enable and direction (1=read, 0=write)
//   reg_wr_vld      register-file write enable
//   load_op         LD completing
//   flags           registered {Z,N,C,V}
module risc_eunit_p #(
  parameter int DATA_W  = 8,
  parameter int MADDR_W = 4,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [4:0]         opcode,
  input  logic [DATA_W-1:0]  oprnd_a,
  input  logic [DATA_W-1:0]  oprnd_b,
  input  logic [RADDR_W-1:0] dstin,
  input  logic [MADDR_W-1:0] dmaddrin,
  output logic               out_vld,
  output logic [DATA_W-1:0]  rslt,
  output logic [RADDR_W-1:0] dst,
  output logic [MADDR_W-1:0] dmaddr,
  output logic               dmenbl,
  output logic               rdwr,
  output logic               reg_wr_vld,
  output logic               load_op,
  output logic [3:0]         flags
);

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_AND = 5'h03;
  localparam logic [4:0] OP_OR  = 5'h04;
  localparam logic [4:0] OP_XOR = 5'h05;
  localparam logic [4:0] OP_INC = 5'h06;
  localparam logic [4:0] OP_DEC = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_NEG = 5'h09;
  localparam logic [4:0] OP_SHR = 5'h0A;
  localparam logic [4:0] OP_SHL = 5'h0B;
  localparam logic [4:0] OP_ROR = 5'h0C;
  localparam logic [4:0] OP_ROL = 5'h0D;
  localparam logic [4:0] OP_LD  = 5'h0E;
  localparam logic [4:0] OP_ST  = 5'h0F;
  localparam logic [4:0] OP_MUL = 5'h10;
  localparam logic [4:0] OP_CMP = 5'h11;

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W:0]   W_LIM    = (DATA_W+1)'(DATA_W);
  localparam logic [DATA_W-1:0] W_MOD    = DATA_W'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_RUN,
    S_MUL_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_out_vld;
  logic [4:0]            r_op;
  logic [DATA_W-1:0]     r_rslt;
  logic [RADDR_W-1:0]    r_dst;
  logic [MADDR_W-1:0]    r_dmaddr;
  logic [3:0]            r_flags;

  logic [2*DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]     r_mplier;
  logic [2*DATA_W-1:0]   r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [RADDR_W-1:0]    r_mdst;

  logic                  w_rdy;
  logic                  w_accept;
  logic                  w_is_mul;

  logic [DATA_W-1:0]     w_add_x;
  logic [DATA_W-1:0]     w_add_y;
  logic                  w_add_cin;
  logic [DATA_W:0]       w_sum;

  logic [DATA_W-1:0]     w_shr;
  logic [DATA_W-1:0]     w_shl;
  logic [DATA_W-1:0]     w_rot_amt;
  logic [DATA_W-1:0]     w_rot_inv;
  logic [DATA_W-1:0]     w_ror;
  logic [DATA_W-1:0]     w_rol;

  logic [DATA_W-1:0]     w_res;
  logic                  w_c;
  logic                  w_v;
  logic                  w_arith;
  logic                  w_upd_flags;
  logic                  w_wr_rslt;

  logic [DATA_W-1:0]     w_mul_lo;
  logic [DATA_W-1:0]     w_mul_hi;

  // in_rdy is a pure function of state; no path from in_vld.
  assign w_rdy    = (r_state == S_IDLE);
  assign w_accept = in_vld & w_rdy & ~flush;
  assign w_is_mul = (opcode == OP_MUL);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_accept && w_is_mul) w_state_nxt = S_MUL_RUN;
        S_MUL_RUN:  if (r_cnt == CNT_ONE)     w_state_nxt = S_MUL_DONE;
        S_MUL_DONE: w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------- shifter / rotator ----------------
  always_comb begin
    w_shr = '0;
    w_shl = '0;
    if ({1'b0, oprnd_b} < W_LIM) begin
      w_shr = oprnd_a >> oprnd_b;
      w_shl = oprnd_a << oprnd_b;
    end
  end

  // Rotate built from two opposing shifts; an amount of 0 makes the
  // complementary shift equal DATA_W, which yields 0 and leaves a intact.
  assign w_rot_amt = oprnd_b % W_MOD;
  assign w_rot_inv = W_MOD - w_rot_amt;
  assign w_ror     = (oprnd_a >> w_rot_amt) | (oprnd_a << w_rot_inv);
  assign w_rol     = (oprnd_a << w_rot_amt) | (oprnd_a >> w_rot_inv);

  // ---------------- single shared adder ----------------
  assign w_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {{DATA_W{1'b0}}, w_add_cin};

  always_comb begin
    w_add_x     = oprnd_a;
    w_add_y     = oprnd_b;
    w_add_cin   = 1'b0;
    w_arith     = 1'b0;
    w_upd_flags = 1'b1;
    w_wr_rslt   = 1'b1;
    w_res       = oprnd_a;
    case (opcode)
      OP_ADD: begin
        w_arith = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        w_add_y   = ~oprnd_b;
        w_add_cin = 1'b1;
        w_arith   = 1'b1;
        w_wr_rslt = (opcode == OP_SUB);
      end
      OP_INC: begin
        w_add_y   = '0;
        w_add_cin = 1'b1;
        w_arith   = 1'b1;
      end
      OP_DEC: begin
        w_add_y   = ~DATA_W'(1);
        w_add_cin = 1'b1;
        w_arith   = 1'b1;
      end
      OP_NEG: begin
        w_add_x   = ~oprnd_a;
        w_add_y   = '0;
        w_add_cin = 1'b1;
        w_arith   = 1'b1;
      end
      OP_AND: w_res = oprnd_a & oprnd_b;
      OP_OR:  w_res = oprnd_a | oprnd_b;
      OP_XOR: w_res = oprnd_a ^ oprnd_b;
      OP_NOT: w_res = ~oprnd_a;
      OP_SHR: w_res = w_shr;
      OP_SHL: w_res = w_shl;
      OP_ROR: w_res = w_ror;
      OP_ROL: w_res = w_rol;
      OP_LD, OP_ST: begin
        w_upd_flags = 1'b0;
      end
      default: begin
        // NOP, MUL (handled by the FSM) and undefined codes
        w_upd_flags = 1'b0;
        w_wr_rslt   = 1'b0;
      end
    endcase
    if (w_arith) w_res = w_sum[DATA_W-1:0];
  end

  assign w_c = w_arith & w_sum[DATA_W];
  // Signed overflow: both adder inputs share a sign that the sum does not.
  assign w_v = w_arith & (w_add_x[DATA_W-1] == w_add_y[DATA_W-1]) &
               (w_sum[DATA_W-1] != w_add_x[DATA_W-1]);

  assign w_mul_lo = r_acc[DATA_W-1:0];
  assign w_mul_hi = r_acc[2*DATA_W-1:DATA_W];

  // ---------------- output registers / multiplier datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_op      <= OP_NOP;
      r_rslt    <= '0;
      r_dst     <= '0;
      r_dmaddr  <= '0;
      r_flags   <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_mdst    <= '0;
    end else if (flush) begin
      r_out_vld <= 1'b0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_out_vld <= 1'b0;
        r_mcand   <= {{DATA_W{1'b0}}, oprnd_a};
        r_mplier  <= oprnd_b;
        r_acc     <= '0;
        r_cnt     <= CNT_INIT;
        r_mdst    <= dstin;
      end else begin
        r_out_vld <= 1'b1;
        r_op      <= opcode;
        r_dst     <= dstin;
        r_dmaddr  <= dmaddrin;
        if (w_wr_rslt)   r_rslt  <= w_res;
        if (w_upd_flags) r_flags <= {(w_res == '0), w_res[DATA_W-1], w_c, w_v};
      end
    end else if (r_state == S_MUL_RUN) begin
      r_out_vld <= 1'b0;
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand   <= r_mcand << 1;
      r_mplier  <= r_mplier >> 1;
      r_cnt     <= r_cnt - CNT_ONE;
    end else if (r_state == S_MUL_DONE) begin
      r_out_vld <= 1'b1;
      r_op      <= OP_MUL;
      r_dst     <= r_mdst;
      r_rslt    <= w_mul_lo;
      r_flags   <= {(w_mul_lo == '0), w_mul_lo[DATA_W-1], (w_mul_hi != '0), 1'b0};
    end else begin
      r_out_vld <= 1'b0;
    end
  end

  // ---------------- qualified enables ----------------
  always_comb begin
    reg_wr_vld = 1'b0;
    dmenbl     = 1'b0;
    load_op    = 1'b0;
    rdwr       = 1'b1;
    if (r_out_vld) begin
      reg_wr_vld = (r_op != OP_NOP) && (r_op != OP_ST) && (r_op <= OP_MUL);
      dmenbl     = (r_op == OP_LD) || (r_op == OP_ST);
      load_op    = (r_op == OP_LD);
      rdwr       = (r_op != OP_ST);
    end
  end

  assign in_rdy  = w_rdy;
  assign out_vld = r_out_vld;
  assign rslt    = r_rslt;
  assign dst     = r_dst;
  assign dmaddr  = r_dmaddr;
  assign flags   = r_flags;

endmodule

// File: tb/tb_risc_eunit_p.sv
// tb_risc_eunit_p -- directed self-checking bench for risc_eunit_p (DATA_W=8).
module tb_risc_eunit_p;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_vld;
  logic       in_rdy;
  logic [4:0] opcode;
  logic [7:0] oprnd_a;
  logic [7:0] oprnd_b;
  logic [2:0] dstin;
  logic [3:0] dmaddrin;
  logic       out_vld;
  logic [7:0] rslt;
  logic [2:0] dst;
  logic [3:0] dmaddr;
  logic       dmenbl;
  logic       rdwr;
  logic       reg_wr_vld;
  logic       load_op;
  logic [3:0] flags;

  int n_chk  = 0;
  int n_pass = 0;

  risc_eunit_p #(
    .DATA_W (8),
    .MADDR_W(4),
    .RADDR_W(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .opcode    (opcode),
    .oprnd_a   (oprnd_a),
    .oprnd_b   (oprnd_b),
    .dstin     (dstin),
    .dmaddrin  (dmaddrin),
    .out_vld   (out_vld),
    .rslt      (rslt),
    .dst       (dst),
    .dmaddr    (dmaddr),
    .dmenbl    (dmenbl),
    .rdwr      (rdwr),
    .reg_wr_vld(reg_wr_vld),
    .load_op   (load_op),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Called on a negedge; presents the op for one posedge, returns on the
  // following negedge with outputs describing the op.
  task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] d, input logic [3:0] m);
    opcode   = op;
    oprnd_a  = a;
    oprnd_b  = b;
    dstin    = d;
    dmaddrin = m;
    in_vld   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_vld   = 1'b0;
  endtask

  task automatic check_alu(input string tag, input logic [7:0] r, input logic [3:0] f,
                           input logic wr);
    check({tag, "_vld"},   {31'b0, out_vld},    1);
    check({tag, "_rslt"},  {24'b0, rslt},       {24'b0, r});
    check({tag, "_flags"}, {28'b0, flags},      {28'b0, f});
    check({tag, "_wr"},    {31'b0, reg_wr_vld}, {31'b0, wr});
  endtask

  task automatic watch_no_vld(input string tag);
    logic saw;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_vld) saw = 1'b1;
    end
    check(tag, {31'b0, saw}, 0);
  endtask

  initial begin
    int   cyc;
    logic saw;

    rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0;
    opcode = '0; oprnd_a = '0; oprnd_b = '0; dstin = '0; dmaddrin = '0;
    #2;
    check("rst_vld",   {31'b0, out_vld}, 0);
    check("rst_rslt",  {24'b0, rslt},    0);
    check("rst_flags", {28'b0, flags},   0);
    check("rst_rdwr",  {31'b0, rdwr},    1);
    check("rst_en",    {29'b0, dmenbl, reg_wr_vld, load_op}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", {31'b0, in_rdy}, 1);

    // ADD with carry out
    issue(5'h01, 8'hF0, 8'h20, 3'd1, 4'd2);
    check_alu("add", 8'h10, 4'h2, 1'b1);
    check("add_dst", {29'b0, dst}, 1);
    check("add_rdy", {31'b0, in_rdy}, 1);
    @(posedge clk); @(negedge clk);
    check("pulse_end", {31'b0, out_vld}, 0);
    check("pulse_wr",  {31'b0, reg_wr_vld}, 0);

    // SUB signed overflow, then CMP equal (no write, rslt kept)
    issue(5'h02, 8'h80, 8'h01, 3'd2, 4'd0);
    check_alu("sub", 8'h7F, 4'h3, 1'b1);
    issue(5'h11, 8'h05, 8'h05, 3'd3, 4'd0);
    check_alu("cmp", 8'h7F, 4'hA, 1'b0);

    // shifts and rotates
    issue(5'h0C, 8'h81, 8'd9, 3'd1, 4'd0);
    check_alu("ror", 8'hC0, 4'h4, 1'b1);
    issue(5'h0B, 8'h01, 8'd8, 3'd1, 4'd0);
    check_alu("shl", 8'h00, 4'h8, 1'b1);
    issue(5'h0D, 8'h81, 8'd1, 3'd1, 4'd0);
    check_alu("rol", 8'h03, 4'h0, 1'b1);
    issue(5'h0A, 8'h80, 8'd7, 3'd1, 4'd0);
    check_alu("shr", 8'h01, 4'h0, 1'b1);

    // arithmetic corner cases
    issue(5'h09, 8'h80, 8'h00, 3'd1, 4'd0);
    check_alu("neg", 8'h80, 4'h5, 1'b1);
    issue(5'h06, 8'hFF, 8'h00, 3'd1, 4'd0);
    check_alu("inc", 8'h00, 4'hA, 1'b1);
    issue(5'h07, 8'h00, 8'h00, 3'd1, 4'd0);
    check_alu("dec", 8'hFF, 4'h4, 1'b1);

    // NOP and undefined opcode: pulse but no enables, flags held
    issue(5'h00, 8'h12, 8'h34, 3'd1, 4'd5);
    check_alu("nop", 8'hFF, 4'h4, 1'b0);
    check("nop_mem", {30'b0, dmenbl, rdwr}, 1);
    issue(5'h15, 8'h12, 8'h34, 3'd1, 4'd5);
    check_alu("undef", 8'hFF, 4'h4, 1'b0);

    // MUL with an ADD held on in_vld behind it
    opcode = 5'h10; oprnd_a = 8'h10; oprnd_b = 8'h11; dstin = 3'd5; in_vld = 1'b1;
    @(posedge clk);
    #1;
    opcode = 5'h01; oprnd_a = 8'h01; oprnd_b = 8'h02; dstin = 3'd6;
    cyc = 0; saw = 1'b0;
    @(negedge clk);
    while (!in_rdy && cyc < 20) begin
      if (out_vld) saw = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check("mul_stall", cyc, 9);
    check("mul_quiet", {31'b0, saw}, 0);
    check_alu("mul", 8'h10, 4'h2, 1'b1);
    check("mul_dst", {29'b0, dst}, 5);
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    check_alu("add_after_mul", 8'h03, 4'h0, 1'b1);
    check("add_after_dst", {29'b0, dst}, 6);

    // ST then LD back-to-back
    issue(5'h0F, 8'h5A, 8'h00, 3'd2, 4'h9);
    check("st_mem",   {29'b0, dmenbl, rdwr, load_op}, 3'b100);
    check("st_rslt",  {24'b0, rslt}, 8'h5A);
    check("st_addr",  {28'b0, dmaddr}, 4'h9);
    check("st_wr",    {31'b0, reg_wr_vld}, 0);
    check("st_flags", {28'b0, flags}, 0);
    issue(5'h0E, 8'h33, 8'h00, 3'd4, 4'h3);
    check("ld_mem",  {29'b0, dmenbl, rdwr, load_op}, 3'b111);
    check("ld_addr", {28'b0, dmaddr}, 4'h3);
    check("ld_wr",   {31'b0, reg_wr_vld}, 1);
    check("ld_rslt", {24'b0, rslt}, 8'h33);

    // flush wins over acceptance
    flush = 1'b1;
    issue(5'h01, 8'hF0, 8'h20, 3'd1, 4'd0);
    flush = 1'b0;
    check("flush_drop_vld",  {31'b0, out_vld}, 0);
    check("flush_drop_rslt", {24'b0, rslt}, 8'h33);

    // MUL aborted by flush at E0+4
    issue(5'h01, 8'hF0, 8'h20, 3'd1, 4'd0);
    check_alu("pre_flush", 8'h10, 4'h2, 1'b1);
    opcode = 5'h10; oprnd_a = 8'h0F; oprnd_b = 8'h0F; dstin = 3'd7; in_vld = 1'b1;
    @(posedge clk);
    #1 in_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_rdy",   {31'b0, in_rdy}, 1);
    check("flush_vld",   {31'b0, out_vld}, 0);
    check("flush_flags", {28'b0, flags}, 4'h2);
    check("flush_rslt",  {24'b0, rslt}, 8'h10);
    watch_no_vld("flush_no_vld");

    // MUL aborted by reset
    opcode = 5'h10; oprnd_a = 8'h0F; oprnd_b = 8'h0F; dstin = 3'd7; dmaddrin = 4'h0;
    in_vld = 1'b1;
    @(posedge clk);
    #1 in_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_vld",   {31'b0, out_vld}, 0);
    check("mrst_rslt",  {24'b0, rslt}, 0);
    check("mrst_flags", {28'b0, flags}, 0);
    check("mrst_dst",   {29'b0, dst}, 0);
    check("mrst_addr",  {28'b0, dmaddr}, 0);
    check("mrst_en",    {28'b0, dmenbl, reg_wr_vld, load_op, rdwr}, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_rdy", {31'b0, in_rdy}, 1);
    watch_no_vld("mrst_no_vld");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
